// File: rtl/lcd_capture.sv
// LCD pixel-stream capture: packs 2-bpp pixels four per byte into a
// double-buffered framebuffer, swapping banks only on complete frames.
module lcd_capture #(
   parameter int unsigned WIDTH  = 160,
   parameter int unsigned HEIGHT = 144
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  pixel_data,
   input  logic        pixel_latch,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        clear_err,
   output logic [13:0] fb_A,
   output logic [7:0]  fb_Do,
   output logic        fb_wr_n,
   output logic        fb_cs_n,
   output logic        display_bank,
   output logic        frame_done,
   output logic        err_overrun,
   output logic [7:0]  line
);

   localparam logic [7:0]  W8  = 8'(WIDTH);
   localparam logic [7:0]  H8  = 8'(HEIGHT);
   localparam logic [12:0] BPL = 13'(WIDTH / 4);

   typedef enum logic {UNSYNC, ACTIVE} state_t;

   state_t      state_q, state_d;
   logic        latch_q, hsync_q, vsync_q;
   logic [7:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic [7:0]  acc_q, acc_d;
   logic        disp_q, disp_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        wr_n_q, wr_n_d;
   logic [13:0] a_q, a_d;
   logic [7:0]  do_q, do_d;

   logic        pix_ev, hs_ev, vs_ev;
   logic        in_frame, accept;
   logic [7:0]  x_inc, x_grp, acc_in, flush_data;
   logic [12:0] byte_addr;

   assign pix_ev = pixel_latch & ~latch_q;
   assign hs_ev  = hsync & ~hsync_q;
   assign vs_ev  = vsync & ~vsync_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      acc_d   = acc_q;
      disp_d  = disp_q;
      done_d  = 1'b0;
      err_d   = err_q & ~clear_err;
      wr_n_d  = 1'b1;
      a_d     = a_q;
      do_d    = do_q;

      in_frame = (x_q < W8) && (y_q < H8);
      accept   = (state_q == ACTIVE) && pix_ev && in_frame;
      x_inc    = accept ? x_q + 8'd1 : x_q;
      acc_in   = accept ? {acc_q[5:0], pixel_data} : acc_q;
      // Group of the last accepted pixel; serves both full-byte and flush writes.
      x_grp     = (x_inc - 8'd1) >> 2;
      byte_addr = ({5'd0, y_q} * BPL) + {5'd0, x_grp};

      unique case (x_inc[1:0])
         2'd1:    flush_data = {acc_in[1:0], 6'd0};
         2'd2:    flush_data = {acc_in[3:0], 4'd0};
         2'd3:    flush_data = {acc_in[5:0], 2'd0};
         default: flush_data = acc_in;
      endcase

      unique case (state_q)
         UNSYNC: begin
            if (vs_ev) begin
               state_d = ACTIVE;
               x_d     = '0;
               y_d     = '0;
               acc_d   = '0;
            end
         end
         ACTIVE: begin
            x_d   = x_inc;
            acc_d = acc_in;
            if (pix_ev && !in_frame) err_d = 1'b1;
            if (accept && (x_inc[1:0] == 2'd0)) begin
               wr_n_d = 1'b0;
               a_d    = {~disp_q, byte_addr};
               do_d   = acc_in;
            end
            if (hs_ev || vs_ev) begin
               if ((x_inc[1:0] != 2'd0) && (y_q < H8)) begin
                  wr_n_d = 1'b0;
                  a_d    = {~disp_q, byte_addr};
                  do_d   = flush_data;
               end
               x_d   = '0;
               acc_d = '0;
               if (vs_ev) begin
                  if (y_q == H8) begin
                     disp_d = ~disp_q;
                     done_d = 1'b1;
                  end
                  y_d = '0;
               end else if (y_q < H8) begin
                  y_d = y_q + 8'd1;
               end
            end
         end
         default: state_d = UNSYNC;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= UNSYNC;
         latch_q <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         disp_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wr_n_q  <= 1'b1;
         a_q     <= '0;
         do_q    <= '0;
      end else begin
         state_q <= state_d;
         latch_q <= pixel_latch;
         hsync_q <= hsync;
         vsync_q <= vsync;
         x_q     <= x_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         disp_q  <= disp_d;
         done_q  <= done_d;
         err_q   <= err_d;
         wr_n_q  <= wr_n_d;
         a_q     <= a_d;
         do_q    <= do_d;
      end
   end

   assign fb_A         = a_q;
   assign fb_Do        = do_q;
   assign fb_wr_n      = wr_n_q;
   assign fb_cs_n      = wr_n_q;
   assign display_bank = disp_q;
   assign frame_done   = done_q;
   assign err_overrun  = err_q;
   assign line         = y_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture: hand vectors, a full frame, overrun, short frame,
// mid-line reset and random traffic against a pixel-list reference model.
module tb_lcd_capture;

   localparam int W = 160;
   localparam int H = 144;
   localparam logic [34:0] RST_EXP = {14'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  pixel_data = '0;
   logic        pixel_latch = 1'b0;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic        clear_err = 1'b0;
   logic [13:0] fb_A;
   logic [7:0]  fb_Do;
   logic        fb_wr_n, fb_cs_n, display_bank, frame_done, err_overrun;
   logic [7:0]  line;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   lcd_capture #(.WIDTH(W), .HEIGHT(H)) dut (
      .clock(clock), .reset_n(reset_n), .pixel_data(pixel_data),
      .pixel_latch(pixel_latch), .hsync(hsync), .vsync(vsync),
      .clear_err(clear_err), .fb_A(fb_A), .fb_Do(fb_Do), .fb_wr_n(fb_wr_n),
      .fb_cs_n(fb_cs_n), .display_bank(display_bank), .frame_done(frame_done),
      .err_overrun(err_overrun), .line(line)
   );

   // Reference model: keeps the accepted pixels of the current line as a list.
   bit          m_sync, m_disp, m_err;
   int          m_x, m_y;
   int          m_row[$];
   bit          e_wr, e_fd;
   logic [13:0] e_A;
   logic [7:0]  e_D;

   logic        got_wr_n, got_cs_n, got_fd, got_disp, got_err;
   logic [7:0]  got_line, got_D;
   logic [13:0] got_A, last_A;
   int          nwrites;

   task automatic model_reset();
      m_sync = 0; m_disp = 1; m_err = 0; m_x = 0; m_y = 0;
      m_row.delete();
   endtask

   task automatic model_emit(input int grp);
      logic [7:0] d;
      d = '0;
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = grp * 4 + k;
         if (idx < m_x) d = d | (8'(m_row[idx]) << (6 - 2 * k));
      end
      e_wr = 1;
      e_D  = d;
      e_A  = 14'((m_disp ? 0 : 8192) + m_y * (W / 4) + grp);
   endtask

   task automatic model_step(input bit pl, hs, vs, clr, input logic [1:0] pd);
      bit discard;
      e_wr = 0; e_fd = 0; discard = 0;
      if (!m_sync) begin
         if (vs) begin
            m_sync = 1; m_x = 0; m_y = 0; m_row.delete();
         end
      end else begin
         if (pl) begin
            if (m_x < W && m_y < H) begin
               m_row.push_back(int'(pd));
               m_x++;
               if (m_x % 4 == 0) model_emit(m_x / 4 - 1);
            end else begin
               discard = 1;
            end
         end
         if (hs || vs) begin
            if (m_x % 4 != 0 && m_y < H) model_emit(m_x / 4);
            if (vs) begin
               if (m_y == H) begin
                  e_fd = 1;
                  m_disp = !m_disp;
               end
               m_y = 0;
            end else if (m_y < H) begin
               m_y++;
            end
            m_x = 0;
            m_row.delete();
         end
      end
      m_err = (m_err && !clr) || discard;
   endtask

   task automatic check(input string nm, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", nm, act, exp);
      end
   endtask

   // Drives one event for a cycle, captures the response, then idles a cycle.
   task automatic step(input bit pl, hs, vs, clr, input logic [1:0] pd);
      pixel_latch = pl; hsync = hs; vsync = vs; clear_err = clr; pixel_data = pd;
      model_step(pl, hs, vs, clr, pd);
      @(negedge clock);
      got_wr_n = fb_wr_n; got_cs_n = fb_cs_n; got_fd = frame_done;
      got_disp = display_bank; got_err = err_overrun; got_line = line;
      got_A = fb_A; got_D = fb_Do;
      if (!fb_wr_n) begin
         nwrites++;
         last_A = fb_A;
      end
      pixel_latch = 0; hsync = 0; vsync = 0; clear_err = 0;
      @(negedge clock);
      check("idle", {33'd0, fb_wr_n, frame_done}, {33'd0, 2'b10});
   endtask

   task automatic check_model(input string nm);
      logic [34:0] exp, act;
      exp = {~e_wr, ~e_wr, e_fd, m_disp, m_err, 8'(m_y),
             e_wr ? e_A : 14'd0, e_wr ? e_D : 8'd0};
      act = {got_wr_n, got_cs_n, got_fd, got_disp, got_err, got_line,
             e_wr ? got_A : 14'd0, e_wr ? got_D : 8'd0};
      check(nm, act, exp);
   endtask

   typedef struct {
      bit pl; bit hs; bit vs; bit clr; logic [1:0] pd;
      bit wr; logic [13:0] a; logic [7:0] d; bit fd; bit disp; bit err; logic [7:0] ln;
   } vec_t;
   vec_t tbl[$];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [34:0] outv;
      model_reset();
      nwrites = 0;
      last_A = '0;

      //            pl hs vs clr pd   wr addr     data   fd disp err line
      tbl.push_back('{1, 0, 0, 0, 2'd3, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 0, 2'd2, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{0, 1, 0, 0, 2'd0, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{0, 0, 1, 0, 2'd0, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 0, 2'd3, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 0, 2'd2, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 0, 2'd1, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 0, 2'd0, 1, 14'h0000, 8'hE4, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 0, 2'd3, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 1, 0, 0, 2'd3, 1, 14'h0001, 8'hF0, 0, 1, 0, 8'd1});
      tbl.push_back('{1, 0, 0, 0, 2'd1, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd1});
      tbl.push_back('{1, 0, 0, 0, 2'd1, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd1});
      tbl.push_back('{1, 0, 0, 0, 2'd1, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd1});
      tbl.push_back('{1, 0, 0, 0, 2'd1, 1, 14'h0028, 8'h55, 0, 1, 0, 8'd1});
      tbl.push_back('{0, 1, 1, 0, 2'd0, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{1, 0, 0, 0, 2'd2, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{0, 0, 1, 0, 2'd0, 1, 14'h0000, 8'h80, 0, 1, 0, 8'd0});
      tbl.push_back('{0, 0, 0, 1, 2'd0, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});
      tbl.push_back('{0, 1, 0, 0, 2'd0, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd1});
      tbl.push_back('{0, 0, 1, 0, 2'd0, 0, 14'h0000, 8'h00, 0, 1, 0, 8'd0});

      repeat (3) @(negedge clock);
      outv = {fb_A, fb_Do, fb_wr_n, fb_cs_n, display_bank, frame_done, err_overrun, line};
      check("reset", outv, RST_EXP);
      reset_n = 1;
      @(negedge clock);
      outv = {fb_A, fb_Do, fb_wr_n, fb_cs_n, display_bank, frame_done, err_overrun, line};
      check("reset_release", outv, RST_EXP);

      foreach (tbl[i]) begin
         logic [34:0] exp, act;
         step(tbl[i].pl, tbl[i].hs, tbl[i].vs, tbl[i].clr, tbl[i].pd);
         exp = {~tbl[i].wr, ~tbl[i].wr, tbl[i].fd, tbl[i].disp, tbl[i].err, tbl[i].ln,
                tbl[i].wr ? tbl[i].a : 14'd0, tbl[i].wr ? tbl[i].d : 8'd0};
         act = {got_wr_n, got_cs_n, got_fd, got_disp, got_err, got_line,
                tbl[i].wr ? got_A : 14'd0, tbl[i].wr ? got_D : 8'd0};
         check($sformatf("vec%0d", i), act, exp);
      end

      // Complete frame into bank 0, then swap.
      nwrites = 0;
      for (int ln = 0; ln < H; ln++) begin
         for (int px = 0; px < W; px++) begin
            step(1, 0, 0, 0, 2'($urandom_range(0, 3)));
            check_model("frame_px");
         end
         step(0, 1, 0, 0, 2'd0);
         check_model("frame_hs");
      end
      check("frame_writes", 35'(nwrites), 35'(5760));
      check("frame_last_addr", 35'(last_A), 35'(14'h167F));
      step(0, 0, 1, 0, 2'd0);
      check_model("frame_vs");
      check("frame_swap", {33'd0, got_fd, got_disp}, {33'd0, 2'b10});

      // Overlong line in bank 1, then error clear.
      nwrites = 0;
      for (int px = 0; px < 162; px++) begin
         step(1, 0, 0, 0, 2'($urandom_range(0, 3)));
         check_model("ovr_px");
         if (px == 3) check("bank1_addr", 35'(got_A[13]), 35'(1));
      end
      check("ovr_writes", 35'(nwrites), 35'(40));
      check("ovr_err", 35'(got_err), 35'(1));
      step(0, 0, 0, 1, 2'd0);
      check_model("clr");
      check("clr_err", 35'(got_err), 35'(0));

      // Short frame: no swap, restart at byte 0 of the same bank.
      for (int ln = 0; ln < 100; ln++) begin
         step(0, 1, 0, 0, 2'd0);
         check_model("short_hs");
      end
      step(0, 0, 1, 0, 2'd0);
      check_model("short_vs");
      check("short_noswap", {33'd0, got_fd, got_disp}, {33'd0, 2'b00});
      for (int px = 0; px < 4; px++) begin
         step(1, 0, 0, 0, 2'($urandom_range(0, 3)));
         check_model("short_px");
      end
      check("short_restart_addr", 35'(got_A), 35'(14'h2000));

      // Reset while a write strobe is pending.
      for (int px = 0; px < 3; px++) begin
         step(1, 0, 0, 0, 2'($urandom_range(0, 3)));
         check_model("prerst_px");
      end
      pixel_latch = 1; pixel_data = 2'd1;
      @(negedge clock);
      check("pending_wr", 35'(fb_wr_n), 35'(0));
      reset_n = 0;
      #1;
      outv = {fb_A, fb_Do, fb_wr_n, fb_cs_n, display_bank, frame_done, err_overrun, line};
      check("mid_reset", outv, RST_EXP);
      pixel_latch = 0;
      @(negedge clock);
      reset_n = 1;
      model_reset();
      nwrites = 0;
      for (int px = 0; px < 8; px++) begin
         step(1, 0, 0, 0, 2'($urandom_range(0, 3)));
         check_model("unsync_px");
      end
      step(0, 1, 0, 0, 2'd0);
      check_model("unsync_hs");
      check("unsync_nowrites", 35'(nwrites), 35'(0));
      step(0, 0, 1, 0, 2'd0);
      check_model("resync_vs");
      for (int px = 0; px < 4; px++) begin
         step(1, 0, 0, 0, 2'($urandom_range(0, 3)));
         check_model("resync_px");
      end

      // Random traffic including coincident events.
      for (int i = 0; i < 3000; i++) begin
         bit pl, hs, vs, clr;
         pl  = ($urandom_range(0, 99) < 75);
         hs  = ($urandom_range(0, 999) < 10);
         vs  = ($urandom_range(0, 999) < 4);
         clr = ($urandom_range(0, 99) < 2);
         step(pl, hs, vs, clr, 2'($urandom_range(0, 3)));
         check_model("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
